irq_vector_master: RTL

- Wishbone initiator that services the SoC interrupt controller on behalf of the CPU core.
- On the controller's level interrupt, reads its pending register and priority-encodes the lowest set line.
- Hands the 4-bit vector to the core with a valid/ready handshake, then clears that line in the controller with a write.
- Sits between the controller's Wishbone slave port and the core's interrupt-entry logic.

---
 rtl/irq_vector_master_pkg.sv | 28 ++
 rtl/irq_vector_master_prio_enc.sv | 26 ++
 rtl/irq_vector_master.sv | 136 +++++++++++++
 3 files changed

// File: rtl/irq_vector_master_pkg.sv
// Shared definitions for the interrupt vector master: register map, line count, FSM states.
// Round-robin selection is enabled by defining IRQ_VEC_ROUND_ROBIN_EN.
package irq_pkg;

   localparam int IRQ_LINES = 16;
   localparam int IRQ_VEC_W = 4;

   localparam logic [23:0] IRQ_REG_PENDING = 24'd0;
   localparam logic [23:0] IRQ_REG_CLEAR   = 24'd1;
   localparam logic [23:0] IRQ_REG_MASK    = 24'd2;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      DELIVER,
      CLR,
      SETTLE
   } irq_state_t;

   function automatic logic [IRQ_VEC_W-1:0] lowest_set(input logic [IRQ_LINES-1:0] i_bits);
      lowest_set = '0;
      // Scan downward so the last hit, the lowest index, wins.
      for (int i = IRQ_LINES - 1; i >= 0; i--) begin
         if (i_bits[i]) lowest_set = IRQ_VEC_W'(i);
      end
   endfunction

endpackage

// File: rtl/irq_vector_master_prio_enc.sv
// Combinational 16->4 priority encoder for pending interrupt lines.
// With IRQ_VEC_ROUND_ROBIN_EN the search starts at i_ptr and wraps.
module irq_prio_enc
   import irq_pkg::*;
(
   input  logic [IRQ_LINES-1:0] i_req,
`ifdef IRQ_VEC_ROUND_ROBIN_EN
   input  logic [IRQ_VEC_W-1:0] i_ptr,
`endif
   output logic [IRQ_VEC_W-1:0] o_vec,
   output logic                 o_valid
);

`ifdef IRQ_VEC_ROUND_ROBIN_EN
   logic [IRQ_LINES-1:0] w_above;

   // Lines at or above the pointer take precedence; otherwise fall back to the lowest.
   assign w_above = i_req & ({IRQ_LINES{1'b1}} << i_ptr);
   assign o_vec   = (w_above != '0) ? lowest_set(w_above) : lowest_set(i_req);
`else
   assign o_vec   = lowest_set(i_req);
`endif

   assign o_valid = |i_req;

endmodule

// File: rtl/irq_vector_master.sv
// Wishbone initiator that reads the interrupt controller, hands a vector to the core, then clears it.
// Optional round-robin selection via IRQ_VEC_ROUND_ROBIN_EN.
module irq_vector_master
   import irq_pkg::*;
#(
   parameter logic [23:0] BASE_ADR = 24'h000000,
   parameter int          TIMEOUT  = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_irq,
   output logic                 wb_cyc,
   output logic                 wb_stb,
   output logic                 wb_we,
   input  logic                 wb_ack,
   output logic [23:0]          wb_adr,
   output logic [15:0]          wb_o_dat,
   input  logic [15:0]          wb_i_dat,
   output logic                 o_vec_valid,
   output logic [IRQ_VEC_W-1:0] o_vec,
   input  logic                 i_vec_ready,
   output logic                 o_spurious,
   output logic                 o_bus_err
);

   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

   irq_state_t           r_state;
   logic [CW-1:0]        r_tmo;
   logic [IRQ_VEC_W-1:0] w_enc_vec;
   logic                 w_enc_valid;
`ifdef IRQ_VEC_ROUND_ROBIN_EN
   logic [IRQ_VEC_W-1:0] r_ptr;
`endif

   irq_prio_enc u_enc (
      .i_req   (wb_i_dat),
`ifdef IRQ_VEC_ROUND_ROBIN_EN
      .i_ptr   (r_ptr),
`endif
      .o_vec   (w_enc_vec),
      .o_valid (w_enc_valid)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_tmo       <= '0;
         wb_cyc      <= 1'b0;
         wb_stb      <= 1'b0;
         wb_we       <= 1'b0;
         wb_adr      <= '0;
         wb_o_dat    <= '0;
         o_vec_valid <= 1'b0;
         o_vec       <= '0;
         o_spurious  <= 1'b0;
         o_bus_err   <= 1'b0;
`ifdef IRQ_VEC_ROUND_ROBIN_EN
         r_ptr       <= '0;
`endif
      end else begin
         o_spurious <= 1'b0;
         o_bus_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (i_irq) begin
                  r_state <= RD;
                  r_tmo   <= '0;
                  wb_cyc  <= 1'b1;
                  wb_stb  <= 1'b1;
                  wb_we   <= 1'b0;
                  wb_adr  <= BASE_ADR + IRQ_REG_PENDING;
               end
            end
            RD: begin
               if (wb_ack) begin
                  wb_cyc <= 1'b0;
                  wb_stb <= 1'b0;
                  r_tmo  <= '0;
                  if (w_enc_valid) begin
                     o_vec       <= w_enc_vec;
                     o_vec_valid <= 1'b1;
                     r_state     <= DELIVER;
                  end else begin
                     o_spurious <= 1'b1;
                     r_state    <= SETTLE;
                  end
               end else if (r_tmo == TMO_LAST) begin
                  wb_cyc    <= 1'b0;
                  wb_stb    <= 1'b0;
                  r_tmo     <= '0;
                  o_bus_err <= 1'b1;
                  r_state   <= SETTLE;
               end else begin
                  r_tmo <= r_tmo + CW'(1);
               end
            end
            DELIVER: begin
               if (i_vec_ready) begin
                  o_vec_valid <= 1'b0;
                  r_state     <= CLR;
                  r_tmo       <= '0;
                  wb_cyc      <= 1'b1;
                  wb_stb      <= 1'b1;
                  wb_we       <= 1'b1;
                  wb_adr      <= BASE_ADR + IRQ_REG_CLEAR;
                  wb_o_dat    <= 16'(1) << o_vec;
               end
            end
            CLR: begin
               // A timed-out clear still counts as delivered; the core already has the vector.
               if (wb_ack || (r_tmo == TMO_LAST)) begin
                  wb_cyc    <= 1'b0;
                  wb_stb    <= 1'b0;
                  r_tmo     <= '0;
                  o_bus_err <= !wb_ack;
                  r_state   <= SETTLE;
`ifdef IRQ_VEC_ROUND_ROBIN_EN
                  if (wb_ack) r_ptr <= o_vec + IRQ_VEC_W'(1);
`endif
               end else begin
                  r_tmo <= r_tmo + CW'(1);
               end
            end
            SETTLE: begin
               wb_we    <= 1'b0;
               wb_o_dat <= '0;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
